// File: rtl/kernel_prueba_control_s_axi.sv
`default_nettype none
// AXI4-Lite control slave for kernel_prueba: start/done handshake, interrupt
// block and the scalar/pointer argument registers.
module kernel_prueba_control_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            s_axi_control_awvalid,
    output logic                            s_axi_control_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                            s_axi_control_wvalid,
    output logic                            s_axi_control_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                            s_axi_control_bvalid,
    input  logic                            s_axi_control_bready,
    output logic [1:0]                      s_axi_control_bresp,
    input  logic                            s_axi_control_arvalid,
    output logic                            s_axi_control_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                            s_axi_control_rvalid,
    input  logic                            s_axi_control_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                      s_axi_control_rresp,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    input  logic                            ap_ready,
    output logic [31:0]                     in1,
    output logic [31:0]                     in2,
    output logic [63:0]                     axi00_ptr0,
    output logic                            interrupt
);

    // Word addresses (byte address >> 2) of the register map.
    localparam logic [9:0] ADDR_CTRL  = 10'h000;
    localparam logic [9:0] ADDR_GIE   = 10'h001;
    localparam logic [9:0] ADDR_IER   = 10'h002;
    localparam logic [9:0] ADDR_ISR   = 10'h003;
    localparam logic [9:0] ADDR_IN1   = 10'h004;
    localparam logic [9:0] ADDR_IN2   = 10'h006;
    localparam logic [9:0] ADDR_PTR_L = 10'h008;
    localparam logic [9:0] ADDR_PTR_H = 10'h009;

    // The RESET states keep the ready outputs low while reset is asserted
    // and for the first cycle after it is released.
    typedef enum logic [1:0] {
        WRIDLE  = 2'd0,
        WRDATA  = 2'd1,
        WRRESP  = 2'd2,
        WRRESET = 2'd3
    } wstate_t;

    typedef enum logic [1:0] {
        RDIDLE  = 2'd0,
        RDDATA  = 2'd1,
        RDRESET = 2'd2
    } rstate_t;

    wstate_t     wstate;
    wstate_t     wstate_next;
    rstate_t     rstate;
    rstate_t     rstate_next;

    logic [9:0]  waddr;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic [31:0] rmap;

    logic        auto_restart;
    logic        done_latch;
    logic        gie;
    logic [1:0]  ier;
    logic [1:0]  isr;

    logic        wr_ctrl;
    logic        wr_gie;
    logic        wr_ier;
    logic        wr_isr;
    logic        wr_in1;
    logic        wr_in2;
    logic        wr_ptr_l;
    logic        wr_ptr_h;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wstate <= WRRESET;
        end else begin
            wstate <= wstate_next;
        end
    end

    always_comb begin
        wstate_next           = wstate;
        s_axi_control_awready = 1'b0;
        s_axi_control_wready  = 1'b0;
        s_axi_control_bvalid  = 1'b0;
        case (wstate)
            WRIDLE: begin
                s_axi_control_awready = 1'b1;
                if (s_axi_control_awvalid) begin
                    wstate_next = WRDATA;
                end
            end
            WRDATA: begin
                s_axi_control_wready = 1'b1;
                if (s_axi_control_wvalid) begin
                    wstate_next = WRRESP;
                end
            end
            WRRESP: begin
                s_axi_control_bvalid = 1'b1;
                if (s_axi_control_bready) begin
                    wstate_next = WRIDLE;
                end
            end
            default: wstate_next = WRIDLE;
        endcase
    end

    assign s_axi_control_bresp = 2'b00;
    assign aw_hs = s_axi_control_awvalid & s_axi_control_awready;
    assign w_hs  = s_axi_control_wvalid & s_axi_control_wready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            waddr <= 10'd0;
        end else if (aw_hs) begin
            waddr <= s_axi_control_awaddr[11:2];
        end
    end

    assign wr_ctrl  = w_hs && (waddr == ADDR_CTRL);
    assign wr_gie   = w_hs && (waddr == ADDR_GIE);
    assign wr_ier   = w_hs && (waddr == ADDR_IER);
    assign wr_isr   = w_hs && (waddr == ADDR_ISR);
    assign wr_in1   = w_hs && (waddr == ADDR_IN1);
    assign wr_in2   = w_hs && (waddr == ADDR_IN2);
    assign wr_ptr_l = w_hs && (waddr == ADDR_PTR_L);
    assign wr_ptr_h = w_hs && (waddr == ADDR_PTR_H);

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rstate <= RDRESET;
        end else begin
            rstate <= rstate_next;
        end
    end

    always_comb begin
        rstate_next           = rstate;
        s_axi_control_arready = 1'b0;
        s_axi_control_rvalid  = 1'b0;
        case (rstate)
            RDIDLE: begin
                s_axi_control_arready = 1'b1;
                if (s_axi_control_arvalid) begin
                    rstate_next = RDDATA;
                end
            end
            RDDATA: begin
                s_axi_control_rvalid = 1'b1;
                if (s_axi_control_rready) begin
                    rstate_next = RDIDLE;
                end
            end
            default: rstate_next = RDIDLE;
        endcase
    end

    assign s_axi_control_rresp = 2'b00;
    assign ar_hs = s_axi_control_arvalid & s_axi_control_arready;

    always_comb begin
        rmap = 32'd0;
        case (s_axi_control_araddr[11:2])
            ADDR_CTRL:  rmap = {24'd0, auto_restart, 3'd0, ap_ready, ap_idle, done_latch, ap_start};
            ADDR_GIE:   rmap = {31'd0, gie};
            ADDR_IER:   rmap = {30'd0, ier};
            ADDR_ISR:   rmap = {30'd0, isr};
            ADDR_IN1:   rmap = in1;
            ADDR_IN2:   rmap = in2;
            ADDR_PTR_L: rmap = axi00_ptr0[31:0];
            ADDR_PTR_H: rmap = axi00_ptr0[63:32];
            default:    rmap = 32'd0;
        endcase
    end

    // rdata only moves on the AR handshake, so it stays put while rvalid waits.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s_axi_control_rdata <= '0;
        end else if (ar_hs) begin
            s_axi_control_rdata <= rmap;
        end
    end

    // ------------------------------------------------------------------
    // Control and interrupt registers
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start <= 1'b0;
        end else if (wr_ctrl && s_axi_control_wstrb[0] && s_axi_control_wdata[0]) begin
            ap_start <= 1'b1;
        end else if (ap_ready && !auto_restart) begin
            ap_start <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            auto_restart <= 1'b0;
        end else if (wr_ctrl && s_axi_control_wstrb[0]) begin
            auto_restart <= s_axi_control_wdata[7];
        end
    end

    // A done pulse coinciding with the clearing read must not be lost.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            done_latch <= 1'b0;
        end else if (ap_done) begin
            done_latch <= 1'b1;
        end else if (ar_hs && (s_axi_control_araddr[11:2] == ADDR_CTRL)) begin
            done_latch <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gie <= 1'b0;
            ier <= 2'b00;
        end else begin
            if (wr_gie && s_axi_control_wstrb[0]) begin
                gie <= s_axi_control_wdata[0];
            end
            if (wr_ier && s_axi_control_wstrb[0]) begin
                ier <= s_axi_control_wdata[1:0];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            isr <= 2'b00;
        end else begin
            if (ier[0] && ap_done) begin
                isr[0] <= 1'b1;
            end else if (wr_isr && s_axi_control_wstrb[0]) begin
                isr[0] <= isr[0] ^ s_axi_control_wdata[0];
            end
            if (ier[1] && ap_ready) begin
                isr[1] <= 1'b1;
            end else if (wr_isr && s_axi_control_wstrb[0]) begin
                isr[1] <= isr[1] ^ s_axi_control_wdata[1];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            interrupt <= 1'b0;
        end else begin
            interrupt <= gie & (|isr);
        end
    end

    // ------------------------------------------------------------------
    // Kernel arguments
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in1        <= 32'd0;
            in2        <= 32'd0;
            axi00_ptr0 <= 64'd0;
        end else begin
            if (wr_in1) begin
                in1 <= byte_merge(in1, s_axi_control_wdata, s_axi_control_wstrb);
            end
            if (wr_in2) begin
                in2 <= byte_merge(in2, s_axi_control_wdata, s_axi_control_wstrb);
            end
            if (wr_ptr_l) begin
                axi00_ptr0[31:0] <= byte_merge(axi00_ptr0[31:0], s_axi_control_wdata,
                                               s_axi_control_wstrb);
            end
            if (wr_ptr_h) begin
                axi00_ptr0[63:32] <= byte_merge(axi00_ptr0[63:32], s_axi_control_wdata,
                                                s_axi_control_wstrb);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/kernel_prueba_control_s_axi.md
KERNEL_PRUEBA_CONTROL_S_AXI -- requirements
Module: kernel_prueba_control_s_axi

Interface
REQ-001 C_S_AXI_ADDR_WIDTH, default 12, byte-address width of the control slave.
REQ-002 C_S_AXI_DATA_WIDTH, default 32, control data width; only 32 is supported.
REQ-003 ap_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axi_control_awvalid/awready  in/out  1  write-address handshake; awaddr  in  C_S_AXI_ADDR_WIDTH.
REQ-006 s_axi_control_wvalid/wready  in/out  1  write-data handshake; wdata  in  32; wstrb  in  4.
REQ-007 s_axi_control_bvalid/bready  out/in  1  write response; bresp  out  2, always 2'b00.
REQ-008 s_axi_control_arvalid/arready  in/out  1  read-address handshake; araddr  in  C_S_AXI_ADDR_WIDTH.
REQ-009 s_axi_control_rvalid/rready  out/in  1  read data; rdata  out  32; rresp  out  2, always 2'b00.
REQ-010 ap_start  out  1  level start to the kernel datapath.
REQ-011 ap_done, ap_idle, ap_ready  in  1 each  kernel status; ap_done/ap_ready are single-cycle pulses.
REQ-012 in1, in2  out  32 each  scalar arguments; axi00_ptr0  out  64  buffer base address.
REQ-013 interrupt  out  1  level interrupt to host.

Function
REQ-014 Register map (addr[11:0], word-aligned, addr[1:0] ignored): 0x00 CTRL, 0x04 GIE, 0x08 IER, 0x0C ISR, 0x10 in1, 0x18 in2, 0x20 axi00_ptr0[31:0], 0x24 axi00_ptr0[63:32]; all other addresses read 0, writes ignored, response still OKAY.
REQ-015 CTRL bits: [0] ap_start RW, [1] ap_done COR, [2] ap_idle RO (live input), [3] ap_ready RO (live input), [7] auto_restart RW; other bits read 0.
REQ-016 Write FSM states WRIDLE->WRDATA->WRRESP->WRIDLE: awready=1 only in WRIDLE, address latched on AW handshake; wready=1 only in WRDATA, register updated on W handshake; bvalid=1 only in WRRESP, leaves on bready.
REQ-017 Read FSM states RDIDLE->RDDATA->RDIDLE: arready=1 only in RDIDLE; rdata registered from the map on AR handshake, valid next cycle; rvalid and rdata held stable until rready.
REQ-018 Write and read channels operate independently and may complete in the same cycle.
REQ-019 Byte strobes apply per byte to in1, in2, both pointer halves, and CTRL[7:0]; strobe=0 bytes unchanged.
REQ-020 ap_start set on CTRL write with wstrb[0]=1 and wdata[0]=1; cleared on ap_ready pulse when auto_restart=0; held when auto_restart=1; writing 0 does not clear it.
REQ-021 ap_done latch set on ap_done pulse; cleared on the AR handshake to 0x00; simultaneous set and clear leaves it set.
REQ-022 GIE bit0, IER bits[1:0] RW; ISR[0] set on ap_done when IER[0]=1, ISR[1] set on ap_ready when IER[1]=1; writing 1 to an ISR bit toggles it; a set event in the same cycle wins over toggle.
REQ-023 interrupt = GIE[0] AND (ISR[0] OR ISR[1]), registered, one cycle after ISR change.
REQ-024 in1, in2, axi00_ptr0 drive outputs directly from their registers, updated the cycle after the W handshake.

Reset
REQ-025 On ap_rst_n=0, immediately: both FSMs to idle, awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rdata=0, ap_start=0, ap_done latch=0, auto_restart=0, GIE=0, IER=0, ISR=0, interrupt=0, in1=in2=0, axi00_ptr0=0.
REQ-026 Reset mid-transaction abandons it with no response; first transfer after deassertion is accepted normally.

Verification
REQ-027 Write 0x10=0x0000_0005, 0x20=0x8000_0000, 0x24=0x0000_0001, read back -> in1=5, axi00_ptr0=0x1_8000_0000, same values on rdata, bresp/rresp=0.
REQ-028 Write CTRL=0x1, drive ap_ready+ap_done pulse 20 cycles later -> ap_start 1 for exactly those cycles, low next cycle; read CTRL -> bit1=1; second read -> bit1=0.
REQ-029 GIE=1, IER=0x1, ap_done pulse -> ISR=0x1, interrupt=1 one cycle later; write ISR=0x1 -> ISR=0, interrupt=0.
REQ-030 auto_restart: write CTRL=0x81, three ap_ready pulses -> ap_start stays 1 throughout.
REQ-031 Write 0x10 with wstrb=0b0010, wdata=0xAABBCCDD onto in1=0x11223344 -> in1=0x1122CC44.
REQ-032 Assert ap_rst_n=0 while in WRDATA with rvalid=1 pending -> all outputs at REQ-025 values same cycle; post-reset read 0x00 returns 0x4 when ap_idle=1.
